// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port, word-addressed data memory between two requesters.
// Port 0 is the CPU MEM stage and port 1 is the program loader / debug DMA.
// Each accepted request runs through the same fixed sequence:
//   IDLE   -> pick a winner and latch its request
//   ACCESS -> drive the memory for exactly one cycle
//   RESP   -> pulse the winner's ack with its read data and error flag
// After reset the CPU wins the first contention. Later contentions alternate.
//
// Optional feature (macro DMEM_ARB_LOCK_EN):
//   Adds the input lock1. A port-1 grant taken with lock1 high keeps port 1
//   granted in the following IDLE cycles for as long as req1 and lock1 stay
//   high. This gives the loader atomic bursts.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0         CPU request (word index, write data)
//   ack0/rdata0/err0              CPU completion pulse, read data, range error
//   req1/we1/addr1/wdata1         DMA request
//   lock1                         DMA burst lock (only with DMEM_ARB_LOCK_EN)
//   ack1/rdata1/err1              DMA completion pulse, read data, range error
//   mem_address/mem_write_data    memory address / write data (registered)
//   mem_read/mem_write            memory strobes (registered, ACCESS only)
//   mem_read_data                 combinational memory read data
//   busy                          high whenever the sequencer is not in IDLE
module dmem_arbiter #(
    parameter int unsigned MEM_SIZE     = 256,
    parameter int unsigned MEM_SIZE_BIT = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic [31:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic        lock1,
`endif
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        err1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data,
    output logic        busy
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Transaction context latched in IDLE on a grant
    logic sel_q;        // winning port
    logic we_q;         // write (1) / read (0)
    logic oor_q;        // address was outside the memory
    logic last_grant_q; // port granted most recently

    // Arbitration decision for the current IDLE cycle
    logic grant_c;
    logic gsel_c;
    logic lock_hold_c;

    // Request fields of the port that wins this cycle
    logic          sel_we_c;
    logic [DW-1:0] sel_addr_c;
    logic [DW-1:0] sel_wdata_c;
    logic          in_range_c;
    logic [DW-1:0] cap_c;

    // Next values of the registered outputs
    logic          ack0_d, ack1_d, err0_d, err1_d, busy_d;
    logic [DW-1:0] rdata0_d, rdata1_d;
    logic [DW-1:0] mem_address_d, mem_write_data_d;
    logic          mem_read_d, mem_write_d;

`ifdef DMEM_ARB_LOCK_EN
    logic lock_q;

    // Port 1 keeps the bus while its locked burst continues
    assign lock_hold_c = lock_q && req1 && lock1;

    // Lock is taken by a locked port-1 grant and re-evaluated on every IDLE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= 1'b0;
        end else if (state_q == IDLE) begin
            lock_q <= grant_c && gsel_c && lock1;
        end
    end
`else
    assign lock_hold_c = 1'b0;
`endif

    // Fields of the port that wins in this cycle
    assign sel_we_c    = gsel_c ? we1    : we0;
    assign sel_addr_c  = gsel_c ? addr1  : addr0;
    assign sel_wdata_c = gsel_c ? wdata1 : wdata0;
    assign in_range_c  = sel_addr_c < DW'(MEM_SIZE);

    // Read data as returned to the requester: writes and errors return zero
    assign cap_c = (we_q || oor_q) ? '0 : mem_read_data;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and arbitration
    always_comb begin
        state_d = state_q;
        grant_c = 1'b0;
        gsel_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (lock_hold_c) begin
                    grant_c = 1'b1;
                    gsel_c  = 1'b1;
                end else if (req0 && req1) begin
                    // Round-robin: the port that did not win last time wins now
                    grant_c = 1'b1;
                    gsel_c  = ~last_grant_q;
                end else if (req0) begin
                    grant_c = 1'b1;
                    gsel_c  = 1'b0;
                end else if (req1) begin
                    grant_c = 1'b1;
                    gsel_c  = 1'b1;
                end
                if (grant_c) begin
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        mem_address_d    = '0;
        mem_write_data_d = '0;
        mem_read_d       = 1'b0;
        mem_write_d      = 1'b0;
        ack0_d           = 1'b0;
        ack1_d           = 1'b0;
        err0_d           = 1'b0;
        err1_d           = 1'b0;
        rdata0_d         = rdata0;
        rdata1_d         = rdata1;
        busy_d           = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                // Memory strobes are set up so they are live only during ACCESS
                if (grant_c && in_range_c) begin
                    mem_address_d    = DW'(sel_addr_c[MEM_SIZE_BIT-1:0]);
                    mem_write_data_d = sel_wdata_c;
                    mem_read_d       = ~sel_we_c;
                    mem_write_d      = sel_we_c;
                end
            end
            ACCESS: begin
                // Memory data is captured on the edge that ends ACCESS
                if (sel_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = oor_q;
                    rdata1_d = cap_c;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = oor_q;
                    rdata0_d = cap_c;
                end
            end
            default: ;
        endcase
    end

    // Transaction context and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (state_q == IDLE && grant_c) begin
            sel_q        <= gsel_c;
            we_q         <= sel_we_c;
            oor_q        <= ~in_range_c;
            last_grant_q <= gsel_c;
        end
    end

    // Registered outputs; reset drops the memory strobes immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            err0           <= 1'b0;
            err1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            ack0           <= ack0_d;
            ack1           <= ack1_d;
            err0           <= err0_d;
            err1           <= err1_d;
            rdata0         <= rdata0_d;
            rdata1         <= rdata1_d;
            mem_address    <= mem_address_d;
            mem_write_data <= mem_write_data_d;
            mem_read       <= mem_read_d;
            mem_write      <= mem_write_d;
            busy           <= busy_d;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer that shares the single-port word-addressed data memory between the CPU MEM stage (port 0) and the program loader/debug DMA (port 1).
- Each requester uses a req/ack handshake. The arbiter picks a winner, drives the memory's Address/Write_data/MemRead/MemWrite for exactly one cycle, and returns registered read data with an ack pulse.
- Sits between the pipeline/loader and the data memory; the CPU stalls on !ack0.

Parameters:
- MEM_SIZE, 256, number of 32-bit words in the attached data memory.
- MEM_SIZE_BIT, 8, address bits needed to index MEM_SIZE words.

Ports:
- clk  in  1  single system clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req0  in  1  CPU request; hold with addr0/we0/wdata0 stable until ack0.
- we0  in  1  CPU write (1) / read (0).
- addr0  in  32  CPU word index.
- wdata0  in  32  CPU write data.
- ack0  out  1  one-cycle completion pulse to CPU.
- rdata0  out  32  CPU read data, valid when ack0.
- err0  out  1  out-of-range flag, valid when ack0.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same as port 0, for DMA.
- mem_address  out  32  to memory Address.
- mem_write_data  out  32  to memory Write_data.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_read_data  in  32  from memory Read_data (combinational).
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (reset_n low, async): state=IDLE, last_grant=1; all outputs 0 (acks, errs, rdata, mem_* buses, busy).
- FSM states:
  - IDLE:
    - Sample req0/req1. Neither -> stay.
    - One -> grant it.
    - Both -> grant the port != last_grant (round-robin; CPU wins first contention after reset).
    - On grant: latch sel, we, addr, wdata into internal regs; update last_grant; go to ACCESS.
  - ACCESS (exactly 1 cycle):
    - If latched addr < MEM_SIZE: mem_address = {zero-extend addr[MEM_SIZE_BIT-1:0]}, mem_read = !we, mem_write = we, mem_write_data = wdata.
    - Capture mem_read_data into the rdata register at the posedge ending this cycle. The memory write commits on the same edge.
    - If addr >= MEM_SIZE: all mem_* stay 0 and err is set.
    - Go to RESP.
  - RESP (1 cycle):
    - ack of the selected port = 1; its rdata = captured data (0 for writes and for errors); err as computed.
    - Other port's ack/err stay 0. Go to IDLE.
- mem_* outputs are 0 in every state other than ACCESS. No memory access is ever issued outside ACCESS.
- Latency: req sampled high at edge N -> ack high during cycle N+2. Max throughput is 1 access per 3 cycles.
- Requester may keep req high through ack to issue a back-to-back request. It is re-sampled in IDLE at N+3 together with the other requester, so round-robin alternates under continuous contention.
- rdataX holds its value after ack until that port's next ack. errX clears to 0 when ackX falls.
- Requests that change or drop before ack are illegal; the arbiter uses only values latched in IDLE.
- A reset assertion mid-transaction aborts it immediately: no ack, and mem_write drops asynchronously. A write in ACCESS that has not reached the clock edge is lost.

Optional Feature:
- Macro DMEM_ARB_LOCK_EN adds input lock1 (1 bit).
- With the macro: if port 1 is granted with lock1=1, the next IDLE grants port 1 regardless of req0 while req1 and lock1 remain high. The lock releases when lock1 or req1 is seen low in IDLE. This gives the loader atomic bursts; the CPU stalls meanwhile.
- Without the macro: no lock1 port; pure round-robin.

Test Plan:
- Single CPU write then read: req0, we0=1, addr0=5, wdata0=0xDEADBEEF -> mem_write=1 with mem_address=5 for 1 cycle, ack0 two cycles after request. Then read addr0=5 -> ack0 with rdata0=0xDEADBEEF, err0=0.
- Simultaneous contention after reset: req0 and req1 both held high, 4 transactions -> grant order 0,1,0,1. Each ack 1 cycle, never overlapping; acks 3 cycles apart.
- Out-of-range: DMA read addr1=256 (MEM_SIZE=256) -> mem_read/mem_write stay 0, ack1=1, err1=1, rdata1=0.
- Reset mid-access: assert reset_n low during ACCESS of a write to addr 7 -> mem_write and all acks 0 immediately, busy=0. After release, a read of addr 7 returns the memory's reset contents.
- Idle behaviour: no requests for 10 cycles -> busy=0 and all mem_* = 0 throughout.
- With DMEM_ARB_LOCK_EN: lock1=1, req1 held for 3 writes while req0 is high -> three port-1 grants consecutively, then port 0 is granted after lock1 drops.
